// File: rtl/seq_mag_comp_if.sv
// Start/busy/done handshake and result bundle for the chunked magnitude comparator.
interface seq_mag_comp_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             signed_mode;
  logic             busy;
  logic             done;
  logic             yg;
  logic             yl;
  logic             ye;

  modport master (
    output start, a, b, signed_mode,
    input  busy, done, yg, yl, ye
  );

  modport slave (
    input  start, a, b, signed_mode,
    output busy, done, yg, yl, ye
  );
endinterface

// File: rtl/seq_mag_comp.sv
// Multi-cycle magnitude comparator: CHUNK bits per cycle, MSB chunk first.
// state | meaning
// IDLE  | waiting for start; operands latched on acceptance
// BUSY  | comparing one chunk per edge
// DONE  | one-cycle done pulse; yg/yl/ye just updated
module seq_mag_comp #(
  parameter int WIDTH      = 8,
  parameter int CHUNK      = 2,
  parameter int EARLY_EXIT = 1
) (
  input logic          clk,
  input logic          rst_n,
  seq_mag_comp_if.slave bus
);
  localparam int NCH = WIDTH / CHUNK;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  generate
    if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_param
      $error("seq_mag_comp: illegal WIDTH/CHUNK combination");
    end
  endgenerate

  logic [1:0]       state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [CW-1:0]    cnt;
  logic             dec_g;
  logic             dec_l;
  logic             yg_q;
  logic             yl_q;
  logic             ye_q;

  logic [WIDTH-1:0] msb_flip;
  logic [CHUNK-1:0] chunk_a;
  logic [CHUNK-1:0] chunk_b;
  logic             decided;
  logic             new_g;
  logic             new_l;
  logic             last;
  logic             early_hit;

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  assign msb_flip = WIDTH'(bus.signed_mode) << (WIDTH - 1);

  // Operand regs shift left each cycle so the active chunk is always on top.
  always_comb begin
    chunk_a   = a_q[WIDTH-1 -: CHUNK];
    chunk_b   = b_q[WIDTH-1 -: CHUNK];
    decided   = dec_g | dec_l;
    new_g     = decided ? dec_g : (chunk_a > chunk_b);
    new_l     = decided ? dec_l : (chunk_a < chunk_b);
    last      = (cnt == CW'(NCH - 1));
    early_hit = (EARLY_EXIT != 0) && !decided && (chunk_a != chunk_b);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      cnt   <= '0;
      dec_g <= 1'b0;
      dec_l <= 1'b0;
      yg_q  <= 1'b0;
      yl_q  <= 1'b0;
      ye_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_q   <= bus.a ^ msb_flip;
            b_q   <= bus.b ^ msb_flip;
            cnt   <= '0;
            dec_g <= 1'b0;
            dec_l <= 1'b0;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (last || early_hit) begin
            yg_q  <= new_g;
            yl_q  <= new_l;
            ye_q  <= ~(new_g | new_l);
            state <= DONE;
          end else begin
            cnt   <= cnt + CW'(1);
            dec_g <= new_g;
            dec_l <= new_l;
            a_q   <= a_q << CHUNK;
            b_q   <= b_q << CHUNK;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = (state == DONE);
  assign bus.yg   = yg_q;
  assign bus.yl   = yl_q;
  assign bus.ye   = ye_q;
endmodule
